// File: rtl/instr_encoder_if.sv
// Descriptor valid/ready handshake plus the instruction-memory write port.
// The master modport drives descriptors and the slave modport encodes them and writes memory.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;

    modport master (
        output in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready, we, waddr, wdata
    );

    modport slave (
        input  in_valid, in_kind, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready, we, waddr, wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: turns RV32I instruction descriptors into machine words and writes them
// sequentially into instruction memory. Define SEAL_HALT_EN to append a jal x0,0 on seal.
module instr_encoder #(
    parameter int ADDR_W     = 6,
    parameter int START_ADDR = 0
) (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  enc,
    input  logic            seal,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            err,
    output logic            sealed
);
    typedef enum logic [1:0] {ST_RUN, ST_FULL, ST_SEALED} state_e;
    typedef enum logic [2:0] {K_LW, K_SW, K_R, K_BEQ, K_IALU, K_JAL} kind_e;

    localparam logic [ADDR_W:0] DEPTH     = (ADDR_W + 1)'(1) << ADDR_W;
    localparam logic [31:0]     HALT_WORD = 32'h0000_006F;
`ifdef SEAL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    state_e            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic              halt_pend_q;

    logic [31:0]       imm;
    logic              fits12, fits13, fits21, is_shift;
    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              accept;
    logic [ADDR_W:0]   occ_d;

    assign imm = enc.in_imm;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        fits12   = (&imm[31:11]) | ~(|imm[31:11]);
        fits13   = (&imm[31:12]) | ~(|imm[31:12]);
        fits21   = (&imm[31:20]) | ~(|imm[31:20]);
        is_shift = (enc.in_funct3 == 3'b001) || (enc.in_funct3 == 3'b101);
        enc_word = '0;
        enc_ok   = 1'b0;
        case (enc.in_kind)
            K_LW: begin
                enc_word = {imm[11:0], enc.in_rs1, 3'b010, enc.in_rd, 7'b0000011};
                enc_ok   = fits12;
            end
            K_SW: begin
                enc_word = {imm[11:5], enc.in_rs2, enc.in_rs1, 3'b010, imm[4:0], 7'b0100011};
                enc_ok   = fits12;
            end
            K_R: begin
                enc_word = {1'b0, enc.in_funct7b5, 5'b00000, enc.in_rs2, enc.in_rs1,
                            enc.in_funct3, enc.in_rd, 7'b0110011};
                enc_ok   = 1'b1;
            end
            K_BEQ: begin
                enc_word = {imm[12], imm[10:5], enc.in_rs2, enc.in_rs1, 3'b000,
                            imm[4:1], imm[11], 7'b1100011};
                enc_ok   = fits13 && !imm[0];
            end
            K_IALU: begin
                // Shifts carry funct7b5 in the upper immediate bits and a 5-bit shamt.
                if (is_shift) begin
                    enc_word = {1'b0, enc.in_funct7b5, 5'b00000, imm[4:0], enc.in_rs1,
                                enc.in_funct3, enc.in_rd, 7'b0010011};
                    enc_ok   = ~(|imm[31:5]);
                end else begin
                    enc_word = {imm[11:0], enc.in_rs1, enc.in_funct3, enc.in_rd, 7'b0010011};
                    enc_ok   = fits12;
                end
            end
            K_JAL: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], enc.in_rd, 7'b1101111};
                enc_ok   = fits21 && !imm[0];
            end
            default: ;
        endcase
    end

    assign accept = enc.in_valid && enc.in_ready;
    // Words committed once the in-flight write and this cycle's accept land.
    assign occ_d  = count_q + (ADDR_W + 1)'(we_q) + (ADDR_W + 1)'(accept && enc_ok);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            we_q        <= 1'b0;
            waddr_q     <= ADDR_W'(START_ADDR);
            wdata_q     <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                waddr_q <= waddr_q + 1'b1;
                count_q <= count_q + 1'b1;
            end
            if (accept) begin
                if (enc_ok) begin
                    we_q    <= 1'b1;
                    wdata_q <= enc_word;
                end else begin
                    err_q <= 1'b1;
                end
            end
            case (state_q)
                ST_RUN, ST_FULL: begin
                    if (seal) begin
                        state_q <= ST_SEALED;
                        if (HALT_EN && occ_d < DEPTH) begin
                            if (accept && enc_ok) begin
                                halt_pend_q <= 1'b1;
                            end else begin
                                we_q    <= 1'b1;
                                wdata_q <= HALT_WORD;
                            end
                        end
                    end else if (state_q == ST_RUN && occ_d == DEPTH) begin
                        state_q <= ST_FULL;
                    end
                end
                default: begin
                    if (halt_pend_q) begin
                        halt_pend_q <= 1'b0;
                        we_q        <= 1'b1;
                        wdata_q     <= HALT_WORD;
                    end
                end
            endcase
        end
    end

    assign enc.in_ready = (state_q == ST_RUN);
    assign enc.we       = we_q;
    assign enc.waddr    = waddr_q;
    assign enc.wdata    = wdata_q;
    assign count        = count_q;
    assign full         = (count_q == DEPTH);
    assign err          = err_q;
    assign sealed       = (state_q == ST_SEALED);
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program-loading cases plus randomized
// descriptor streams compared against an arithmetic reference model of the encodings.
module tb_instr_encoder;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam logic [31:0] HALT = 32'h0000_006F;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          seal = 1'b0;
    logic [AW:0]   count;
    logic          full, err, sealed;

    instr_encoder_if #(.ADDR_W(AW)) enc ();

    instr_encoder #(.ADDR_W(AW), .START_ADDR(0)) dut (
        .clk    (clk),
        .reset  (reset),
        .enc    (enc.slave),
        .seal   (seal),
        .count  (count),
        .full   (full),
        .err    (err),
        .sealed (sealed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int          m_cnt, m_ptr, m_good;
    bit          m_err, m_sealed, p_we, halt_after;
    logic [31:0] p_word;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h expected=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_encode(input int kind, input int f3, input int f7, input int rd,
                                      input int rs1, input int rs2, input int imm,
                                      output logic [31:0] w);
        bit ok;
        ok = 1'b0;
        w  = '0;
        case (kind)
            0: begin
                ok = imm >= -2048 && imm <= 2047;
                w  = ((imm & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
            end
            1: begin
                ok = imm >= -2048 && imm <= 2047;
                w  = (((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                   | ((imm & 'h1F) << 7) | 'h23;
            end
            2: begin
                ok = 1'b1;
                w  = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
            end
            3: begin
                ok = imm >= -4096 && imm <= 4095 && (imm & 1) == 0;
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (((imm >> 1) & 'hF) << 8) | (((imm >> 11) & 1) << 7) | 'h63;
            end
            4: begin
                if (f3 == 1 || f3 == 5) begin
                    ok = imm >= 0 && imm <= 31;
                    w  = (f7 << 30) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
                end else begin
                    ok = imm >= -2048 && imm <= 2047;
                    w  = ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
                end
            end
            5: begin
                ok = imm >= -(1 << 20) && imm < (1 << 20) && (imm & 1) == 0;
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21)
                   | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic bit m_ready();
        return !m_sealed && m_good < DEPTH;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_ptr = 0; m_good = 0;
        m_err = 1'b0; m_sealed = 1'b0; p_we = 1'b0; halt_after = 1'b0;
        p_word = '0;
    endtask

    task automatic check_outputs();
        check("we", 32'(enc.we), 32'(p_we));
        if (p_we) begin
            check("wdata", enc.wdata, p_word);
            check("waddr", 32'(enc.waddr), 32'(m_ptr));
        end
        check("count", 32'(count), 32'(m_cnt));
        check("full", 32'(full), 32'(m_cnt == DEPTH));
        check("err", 32'(err), 32'(m_err));
        check("sealed", 32'(sealed), 32'(m_sealed));
        check("in_ready", 32'(enc.in_ready), 32'(m_ready()));
    endtask

    // One clock cycle: check current outputs, drive inputs, advance the model past the edge.
    task automatic cyc(input bit v, input int kind, input int f3, input int f7, input int rd,
                       input int rs1, input int rs2, input int imm, input bit sl);
        logic [31:0] w;
        bit ok, acc, nwe;
        logic [31:0] nword;
        check_outputs();
        enc.in_valid    = v;
        enc.in_kind     = 3'(kind);
        enc.in_funct3   = 3'(f3);
        enc.in_funct7b5 = 1'(f7);
        enc.in_rd       = 5'(rd);
        enc.in_rs1      = 5'(rs1);
        enc.in_rs2      = 5'(rs2);
        enc.in_imm      = imm;
        seal            = sl;
        ok  = ref_encode(kind, f3, f7, rd, rs1, rs2, imm, w);
        acc = v && m_ready();
        @(posedge clk);
        #1;
        if (p_we) begin
            m_ptr = (m_ptr + 1) % DEPTH;
            m_cnt++;
        end
        nwe   = 1'b0;
        nword = p_word;
        if (!m_sealed) begin
            if (acc && ok) begin
                nwe = 1'b1; nword = w; m_good++;
            end
            if (acc && !ok) m_err = 1'b1;
            if (sl) begin
                m_sealed = 1'b1;
`ifdef SEAL_HALT_EN
                if (m_good < DEPTH) begin
                    if (acc && ok) halt_after = 1'b1;
                    else begin nwe = 1'b1; nword = HALT; m_good++; end
                end
`endif
            end
        end else if (halt_after) begin
            nwe = 1'b1; nword = HALT; halt_after = 1'b0; m_good++;
        end
        p_we   = nwe;
        p_word = nword;
        enc.in_valid = 1'b0;
        seal         = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enc.in_valid = 1'b0;
        seal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst_wdata", enc.wdata, 32'h0);
        check("rst_waddr", 32'(enc.waddr), 32'h0);
        reset = 1'b0;
    endtask

    function automatic int rand_imm();
        int pick;
        int edges[14] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                          31, 32, (1 << 20) - 2, 1 << 20, -(1 << 20), -(1 << 20) - 2};
        pick = int'($urandom_range(0, 3));
        case (pick)
            0: return int'($urandom_range(0, 80)) - 40;
            1: return edges[$urandom_range(0, 13)];
            2: return int'($urandom_range(0, 31));
            default: return int'($urandom);
        endcase
    endfunction

    initial begin
        enc.in_valid = 1'b0; enc.in_kind = '0; enc.in_funct3 = '0; enc.in_funct7b5 = 1'b0;
        enc.in_rd = '0; enc.in_rs1 = '0; enc.in_rs2 = '0; enc.in_imm = '0;
        do_reset();

        // lw / add / sub back to back
        cyc(1, 0, 0, 0, 5, 2, 0, 8, 0);
        check("tp_lw", enc.wdata, 32'h00812283);
        cyc(1, 2, 0, 0, 3, 1, 2, 0, 0);
        check("tp_add", enc.wdata, 32'h002081B3);
        cyc(1, 2, 0, 1, 3, 1, 2, 0, 0);
        check("tp_sub", enc.wdata, 32'h402081B3);
        check("tp_sub_addr", 32'(enc.waddr), 32'd2);
        idle();
        check("tp_count3", 32'(count), 32'd3);

        // beq / jal
        do_reset();
        cyc(1, 3, 0, 0, 0, 1, 2, -4, 0);
        check("tp_beq", enc.wdata, 32'hFE208EE3);
        cyc(1, 5, 0, 0, 1, 0, 0, 2048, 0);
        check("tp_jal", enc.wdata, 32'h001000EF);
        idle();

        // illegal descriptors are consumed without writing
        do_reset();
        cyc(1, 4, 0, 0, 1, 1, 0, 2048, 0);
        check("tp_addi_err", 32'(err), 32'd1);
        cyc(1, 3, 0, 0, 0, 1, 2, 3, 0);
        cyc(1, 7, 0, 0, 0, 0, 0, 0, 0);
        idle();
        check("tp_err_count", 32'(count), 32'd0);

        // fill a 4-word memory with five back-to-back descriptors
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1, 2, 0, 0, i + 1, 1, 2, 0, 0);
        idle();
        check("tp_full", 32'(full), 32'd1);
        check("tp_full_ready", 32'(enc.in_ready), 32'd0);
        do_reset();
        idle();
        check("tp_rst_count", 32'(count), 32'd0);
        check("tp_rst_ready", 32'(enc.in_ready), 32'd1);

        // seal together with an accept
        do_reset();
        cyc(1, 1, 0, 0, 0, 2, 5, 12, 1);
        check("tp_sw", enc.wdata, 32'h00512623);
        check("tp_sw_we", 32'(enc.we), 32'd1);
        idle();
        check("tp_sealed", 32'(sealed), 32'd1);
`ifdef SEAL_HALT_EN
        check("tp_halt", enc.wdata, HALT);
        check("tp_halt_addr", 32'(enc.waddr), 32'd1);
`endif
        cyc(1, 2, 0, 0, 1, 1, 1, 0, 1);
        idle();

        // reset while a write is pending drops it immediately
        do_reset();
        cyc(1, 2, 0, 0, 1, 1, 1, 0, 0);
        cyc(1, 2, 0, 0, 2, 1, 1, 0, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(enc.we), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        do_reset();
        idle();

        // randomized streams
        for (int r = 0; r < 60; r++) begin
            do_reset();
            for (int c = 0; c < 12; c++) begin
                cyc($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rand_imm(),
                    $urandom_range(0, 19) == 0);
            end
            idle();
            idle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
